// File: rtl/traffic_generator_gmii_axil_regs_if.sv
// AXI4-Lite bus bundle between the PS-side master and the traffic generator register block.
interface traffic_generator_gmii_axil_regs_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/traffic_generator_gmii_axil_regs.sv
// AXI4-Lite register block for the GMII traffic generator: control/IFG/frame-size registers,
// template RAM write streaming and coherent 64-bit statistics readback.
module traffic_generator_gmii_axil_regs #(
    parameter logic [31:0] IP_ID     = 32'h7467_0001,
    parameter int          TPL_DEPTH = 64,
    parameter int          ADDR_W    = 8
) (
    input  logic                           aclk,
    input  logic                           arstn,
    traffic_generator_gmii_axil_regs_if.slave s_axi,
    output logic                           ctrl_enable,
    output logic                           ctrl_dynamic,
    output logic [31:0]                    ifg,
    output logic [31:0]                    frame_size,
    output logic                           tpl_we,
    output logic [$clog2(TPL_DEPTH)-1:0]   tpl_addr,
    output logic [31:0]                    tpl_wdata,
    output logic [$clog2(TPL_DEPTH):0]     tpl_len,
    input  logic [63:0]                    stat_pkts,
    input  logic [63:0]                    stat_octets
);
    localparam int TPL_AW = $clog2(TPL_DEPTH);
    localparam logic [TPL_AW:0] TPL_FULL = (TPL_AW + 1)'(TPL_DEPTH);
    localparam logic [TPL_AW:0] PTR_ONE  = (TPL_AW + 1)'(1);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));
    localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_FLIP    = ADDR_W'(8'h0C);
    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(8'h10);
    localparam logic [ADDR_W-1:0] A_IFG     = ADDR_W'(8'h14);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(8'h18);
    localparam logic [ADDR_W-1:0] A_PKTS_HI = ADDR_W'(8'h20);
    localparam logic [ADDR_W-1:0] A_PKTS_LO = ADDR_W'(8'h24);
    localparam logic [ADDR_W-1:0] A_OCT_HI  = ADDR_W'(8'h28);
    localparam logic [ADDR_W-1:0] A_OCT_LO  = ADDR_W'(8'h2C);
    localparam logic [ADDR_W-1:0] A_FSIZE   = ADDR_W'(8'h44);
    localparam logic [ADDR_W-1:0] A_TCLR    = ADDR_W'(8'h4C);
    localparam logic [ADDR_W-1:0] A_TPUSH   = ADDR_W'(8'h50);

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e          w_state_q, w_state_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic              aw_held_q, aw_held_d;
    logic              w_held_q, w_held_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;

    logic [31:0]       flip_q, flip_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [31:0]       ifg_q, ifg_d;
    logic [31:0]       fsize_q, fsize_d;
    logic [TPL_AW:0]   tpl_ptr_q, tpl_ptr_d;
    logic              ovf_q, ovf_d;
    logic              tpl_we_q, tpl_we_d;
    logic [TPL_AW-1:0] tpl_addr_q, tpl_addr_d;
    logic [31:0]       tpl_wdata_q, tpl_wdata_d;

    r_state_e          r_state_q, r_state_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       pkts_lo_q, pkts_lo_d;
    logic [31:0]       oct_lo_q, oct_lo_d;

    logic [31:0]       status_w;

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return a & WORD_MASK;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    assign status_w = {16'h0000, 8'(tpl_ptr_q), 7'h00, ovf_q};

    // Address and data are parked independently; the register update waits until both are held.
    always_comb begin
        w_state_d   = w_state_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        flip_d      = flip_q;
        ctrl_d      = ctrl_q;
        ifg_d       = ifg_q;
        fsize_d     = fsize_q;
        tpl_ptr_d   = tpl_ptr_q;
        ovf_d       = ovf_q;
        tpl_we_d    = 1'b0;
        tpl_addr_d  = tpl_addr_q;
        tpl_wdata_d = tpl_wdata_q;

        case (w_state_q)
            W_IDLE: begin
                if (aw_held_q && w_held_q) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    w_state_d = W_RESP;
                    case (align(awaddr_q))
                        A_FLIP:  flip_d  = merge_bytes(flip_q, wdata_q, wstrb_q);
                        A_CTRL:  ctrl_d  = wstrb_q[0] ? wdata_q[1:0] : ctrl_q;
                        A_IFG:   ifg_d   = merge_bytes(ifg_q, wdata_q, wstrb_q);
                        A_FSIZE: fsize_d = merge_bytes(fsize_q, wdata_q, wstrb_q);
                        A_TCLR: begin
                            tpl_ptr_d = '0;
                            ovf_d     = 1'b0;
                        end
                        A_TPUSH: begin
                            // A full template saturates rather than wrapping onto word 0.
                            if (tpl_ptr_q < TPL_FULL) begin
                                tpl_we_d    = 1'b1;
                                tpl_addr_d  = tpl_ptr_q[TPL_AW-1:0];
                                tpl_wdata_d = wdata_q;
                                tpl_ptr_d   = tpl_ptr_q + PTR_ONE;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    if (awready_q && s_axi.awvalid) begin
                        aw_held_d = 1'b1;
                        awaddr_d  = s_axi.awaddr;
                    end
                    if (wready_q && s_axi.wvalid) begin
                        w_held_d = 1'b1;
                        wdata_d  = s_axi.wdata;
                        wstrb_d  = s_axi.wstrb;
                    end
                    awready_d = !aw_held_d;
                    wready_d  = !w_held_d;
                end
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
        endcase
    end

    // A hi-word read snapshots the matching lo word so a following lo read stays coherent.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        pkts_lo_d = pkts_lo_q;
        oct_lo_d  = oct_lo_q;

        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arready_q && s_axi.arvalid) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    r_state_d = R_DATA;
                    case (align(s_axi.araddr))
                        A_ID:      rdata_d = IP_ID;
                        A_FLIP:    rdata_d = ~flip_q;
                        A_CTRL:    rdata_d = {30'h0, ctrl_q};
                        A_IFG:     rdata_d = ifg_q;
                        A_STATUS:  rdata_d = status_w;
                        A_PKTS_HI: begin
                            rdata_d   = stat_pkts[63:32];
                            pkts_lo_d = stat_pkts[31:0];
                        end
                        A_PKTS_LO: rdata_d = pkts_lo_q;
                        A_OCT_HI: begin
                            rdata_d  = stat_octets[63:32];
                            oct_lo_d = stat_octets[31:0];
                        end
                        A_OCT_LO:  rdata_d = oct_lo_q;
                        A_FSIZE:   rdata_d = fsize_q;
                        default:   rdata_d = '0;
                    endcase
                end
            end
            R_DATA: begin
                if (s_axi.rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            w_state_q   <= W_IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            flip_q      <= '0;
            ctrl_q      <= '0;
            ifg_q       <= '0;
            fsize_q     <= '0;
            tpl_ptr_q   <= '0;
            ovf_q       <= 1'b0;
            tpl_we_q    <= 1'b0;
            tpl_addr_q  <= '0;
            tpl_wdata_q <= '0;
            r_state_q   <= R_IDLE;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            pkts_lo_q   <= '0;
            oct_lo_q    <= '0;
        end else begin
            w_state_q   <= w_state_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            flip_q      <= flip_d;
            ctrl_q      <= ctrl_d;
            ifg_q       <= ifg_d;
            fsize_q     <= fsize_d;
            tpl_ptr_q   <= tpl_ptr_d;
            ovf_q       <= ovf_d;
            tpl_we_q    <= tpl_we_d;
            tpl_addr_q  <= tpl_addr_d;
            tpl_wdata_q <= tpl_wdata_d;
            r_state_q   <= r_state_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            pkts_lo_q   <= pkts_lo_d;
            oct_lo_q    <= oct_lo_d;
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = 2'b00;

    assign ctrl_enable  = ctrl_q[0];
    assign ctrl_dynamic = ctrl_q[1];
    assign ifg          = ifg_q;
    assign frame_size   = fsize_q;
    assign tpl_we       = tpl_we_q;
    assign tpl_addr     = tpl_addr_q;
    assign tpl_wdata    = tpl_wdata_q;
    assign tpl_len      = tpl_ptr_q;
endmodule

// File: tb/tb_traffic_generator_gmii_axil_regs.sv
// Self-checking bench for traffic_generator_gmii_axil_regs: directed register-map scenarios
// followed by randomized AXI-Lite traffic checked against a register-map reference model.
module tb_traffic_generator_gmii_axil_regs;
    localparam int          TPL_DEPTH = 64;
    localparam int          ADDR_W    = 8;
    localparam int          TPL_AW    = $clog2(TPL_DEPTH);
    localparam logic [31:0] IP_ID     = 32'h7467_0001;

    logic                aclk  = 1'b0;
    logic                arstn = 1'b0;
    logic                ctrl_enable;
    logic                ctrl_dynamic;
    logic [31:0]         ifg;
    logic [31:0]         frame_size;
    logic                tpl_we;
    logic [TPL_AW-1:0]   tpl_addr;
    logic [31:0]         tpl_wdata;
    logic [TPL_AW:0]     tpl_len;
    logic [63:0]         stat_pkts   = '0;
    logic [63:0]         stat_octets = '0;

    traffic_generator_gmii_axil_regs_if #(.ADDR_W(ADDR_W)) bus ();

    traffic_generator_gmii_axil_regs #(
        .IP_ID     (IP_ID),
        .TPL_DEPTH (TPL_DEPTH),
        .ADDR_W    (ADDR_W)
    ) dut (
        .aclk         (aclk),
        .arstn        (arstn),
        .s_axi        (bus),
        .ctrl_enable  (ctrl_enable),
        .ctrl_dynamic (ctrl_dynamic),
        .ifg          (ifg),
        .frame_size   (frame_size),
        .tpl_we       (tpl_we),
        .tpl_addr     (tpl_addr),
        .tpl_wdata    (tpl_wdata),
        .tpl_len      (tpl_len),
        .stat_pkts    (stat_pkts),
        .stat_octets  (stat_octets)
    );

    always #5 aclk = ~aclk;

    int check_count = 0;
    int pass_count  = 0;

    // Reference model of the register map.
    logic [31:0] m_flip, m_ifg, m_fsize, m_pkts_lo, m_oct_lo;
    logic [1:0]  m_ctrl;
    int          m_len;
    bit          m_ovf;
    logic [TPL_AW+31:0] exp_tpl[$];
    logic [TPL_AW+31:0] obs_tpl[$];

    always @(negedge aclk) begin
        if (tpl_we === 1'b1) obs_tpl.push_back({tpl_addr, tpl_wdata});
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got === exp) pass_count++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_flip = '0; m_ifg = '0; m_fsize = '0; m_pkts_lo = '0; m_oct_lo = '0;
        m_ctrl = '0; m_len = 0; m_ovf = 0;
    endtask

    task automatic model_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        case (addr & 8'hFC)
            8'h0C: m_flip  = (m_flip  & ~mask) | (data & mask);
            8'h10: if (strb[0]) m_ctrl = data[1:0];
            8'h14: m_ifg   = (m_ifg   & ~mask) | (data & mask);
            8'h44: m_fsize = (m_fsize & ~mask) | (data & mask);
            8'h4C: begin m_len = 0; m_ovf = 0; end
            8'h50: begin
                if (m_len < TPL_DEPTH) begin
                    exp_tpl.push_back({TPL_AW'(m_len), data});
                    m_len++;
                end else begin
                    m_ovf = 1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_read(input logic [7:0] addr, output logic [31:0] v);
        case (addr & 8'hFC)
            8'h00: v = IP_ID;
            8'h0C: v = ~m_flip;
            8'h10: v = {30'h0, m_ctrl};
            8'h14: v = m_ifg;
            8'h18: v = {16'h0, 8'(m_len), 7'h0, m_ovf};
            8'h20: begin v = stat_pkts[63:32]; m_pkts_lo = stat_pkts[31:0]; end
            8'h24: v = m_pkts_lo;
            8'h28: begin v = stat_octets[63:32]; m_oct_lo = stat_octets[31:0]; end
            8'h2C: v = m_oct_lo;
            8'h44: v = m_fsize;
            default: v = '0;
        endcase
    endtask

    // Issue one write; lat counts falling edges from the last address/data handshake to bvalid.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output int lat);
        bit aw_done = 0, w_done = 0, b_done = 0, aw_hs, w_hs;
        int n = 0;
        lat = 0;
        bus.awaddr = addr; bus.awvalid = 1'b1;
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        bus.bready = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            @(negedge aclk); n++;
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(posedge aclk); #1;
            if (aw_hs) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  bus.wvalid = 1'b0;  end
        end
        while (aw_done && w_done && !b_done && n < 50) begin
            @(negedge aclk); n++; lat++;
            if (bus.bvalid) begin
                b_done = 1;
                checkOutput("bresp", bus.bresp, 2'b00);
            end
            @(posedge aclk); #1;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        checkOutput("wr_done", b_done, 1);
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output int lat);
        bit ar_done = 0, r_done = 0, ar_hs;
        int n = 0;
        lat = 0;
        data = 'x;
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
        while (!ar_done && n < 50) begin
            @(negedge aclk); n++;
            ar_hs = bus.arvalid && bus.arready;
            @(posedge aclk); #1;
            if (ar_hs) begin ar_done = 1; bus.arvalid = 1'b0; end
        end
        while (ar_done && !r_done && n < 50) begin
            @(negedge aclk); n++; lat++;
            if (bus.rvalid) begin
                r_done = 1;
                data = bus.rdata;
                checkOutput("rresp", bus.rresp, 2'b00);
            end
            @(posedge aclk); #1;
        end
        bus.arvalid = 1'b0;
        checkOutput("rd_done", r_done, 1);
    endtask

    task automatic applyStimulus(input bit is_write, input logic [7:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb);
        int lat;
        logic [31:0] rd, exp_rd;
        if (is_write) begin
            axi_write(addr, data, strb, lat);
            model_write(addr, data, strb);
            checkOutput("out_ctrl_len", {ctrl_dynamic, ctrl_enable, tpl_len}, {m_ctrl, (TPL_AW+1)'(m_len)});
            checkOutput("out_ifg", ifg, m_ifg);
            checkOutput("out_fsize", frame_size, m_fsize);
        end else begin
            model_read(addr, exp_rd);
            axi_read(addr, rd, lat);
            checkOutput($sformatf("rd_%02h", addr), rd, exp_rd);
        end
    endtask

    task automatic compare_tpl(input string tag);
        checkOutput({tag, "_count"}, obs_tpl.size(), exp_tpl.size());
        for (int i = 0; i < exp_tpl.size() && i < obs_tpl.size(); i++) begin
            checkOutput($sformatf("%s_%0d", tag, i), obs_tpl[i], exp_tpl[i]);
        end
        obs_tpl.delete();
        exp_tpl.delete();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd, exp_rd, old_ifg, new_ifg;
        logic [31:0] tpl_words[18];
        logic [7:0]  addr_pool[14] = '{8'h00, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h20, 8'h24,
                                      8'h28, 8'h2C, 8'h44, 8'h4C, 8'h50, 8'h34, 8'hFC};
        int lat, wlat, rlat, stalls, bhigh, bcount;
        bit w_seen, aw_seen;

        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
        model_reset();

        repeat (3) @(posedge aclk);
        #1;
        checkOutput("rst_handshake", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 5'b0);
        checkOutput("rst_ctrl", {ctrl_enable, ctrl_dynamic, tpl_we, tpl_len}, '0);
        checkOutput("rst_ifg_fsize", {ifg, frame_size}, 64'h0);
        arstn = 1'b1;
        @(posedge aclk); #1;

        axi_read(8'h00, rd, lat);
        checkOutput("ip_id", rd, 32'h7467_0001);
        checkOutput("rd_latency", lat, 1);
        checkOutput("idle_bvalid", bus.bvalid, 1'b0);
        checkOutput("post_rst_en_len", {ctrl_enable, tpl_len}, '0);

        applyStimulus(1, 8'h0C, 32'h1234_5678, 4'hF);
        axi_read(8'h0C, rd, lat);
        checkOutput("flip_full", rd, 32'hEDCB_A987);
        applyStimulus(1, 8'h0C, 32'hFFFF_FFFF, 4'b0001);
        axi_read(8'h0C, rd, lat);
        checkOutput("flip_strb", rd, 32'hEDCB_A900);

        tpl_words[0]  = 32'h5555_5555;
        tpl_words[1]  = 32'h5555_55d5;
        for (int i = 2; i < 17; i++) tpl_words[i] = 32'h0102_0304 + 32'(i - 2) * 32'h0404_0404;
        tpl_words[17] = 32'h344c_a062;
        applyStimulus(1, 8'h4C, 32'h0, 4'hF);
        for (int i = 0; i < 18; i++) applyStimulus(1, 8'h50, tpl_words[i], 4'hF);
        checkOutput("tpl18_count", obs_tpl.size(), 18);
        for (int i = 0; i < 18 && i < obs_tpl.size(); i++) begin
            checkOutput($sformatf("tpl18_entry_%0d", i), obs_tpl[i], {TPL_AW'(i), tpl_words[i]});
        end
        compare_tpl("tpl18");
        axi_read(8'h18, rd, lat);
        checkOutput("status_len18", rd, 32'h0000_1200);
        applyStimulus(1, 8'h10, 32'h3, 4'hF);
        checkOutput("ctrl_bits", {ctrl_dynamic, ctrl_enable}, 2'b11);

        stat_pkts = 64'h0000_0001_FFFF_FFFF;
        model_read(8'h20, exp_rd);
        axi_read(8'h20, rd, lat);
        checkOutput("pkts_hi", rd, 32'h0000_0001);
        stat_pkts = 64'h0000_0002_0000_0005;
        model_read(8'h24, exp_rd);
        axi_read(8'h24, rd, lat);
        checkOutput("pkts_lo", rd, 32'hFFFF_FFFF);
        stat_octets = {$urandom, $urandom};
        applyStimulus(0, 8'h28, 32'h0, 4'h0);
        stat_octets = {$urandom, $urandom};
        applyStimulus(0, 8'h2C, 32'h0, 4'h0);

        applyStimulus(1, 8'h4C, 32'h0, 4'hF);
        for (int i = 0; i < TPL_DEPTH + 1; i++) applyStimulus(1, 8'h50, $urandom, 4'($urandom));
        checkOutput("ovf_pulses", obs_tpl.size(), TPL_DEPTH);
        compare_tpl("ovf");
        axi_read(8'h18, rd, lat);
        checkOutput("status_ovf", rd, 32'h0000_4001);
        applyStimulus(1, 8'h4C, 32'h0, 4'hF);
        axi_read(8'h18, rd, lat);
        checkOutput("status_cleared", rd, 32'h0);

        bus.bready = 1'b0;
        bus.wdata = 32'h0000_05EE; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge aclk); w_seen = bus.wready;
        @(posedge aclk); #1; bus.wvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        checkOutput("early_w_ready", w_seen, 1'b1);
        bus.awaddr = 8'h44; bus.awvalid = 1'b1;
        @(negedge aclk); aw_seen = bus.awready;
        @(posedge aclk); #1; bus.awvalid = 1'b0;
        checkOutput("late_aw_ready", aw_seen, 1'b1);
        @(negedge aclk); checkOutput("b_not_yet", bus.bvalid, 1'b0);
        @(negedge aclk); checkOutput("b_rise", bus.bvalid, 1'b1);
        model_write(8'h44, 32'h0000_05EE, 4'hF);
        checkOutput("fsize_early_w", frame_size, 32'h0000_05EE);
        bus.awaddr = 8'h14; bus.awvalid = 1'b1; bus.wdata = 32'hDEAD_BEEF; bus.wvalid = 1'b1;
        stalls = 0; bhigh = 0;
        repeat (5) begin
            @(negedge aclk);
            if (bus.awready || bus.wready) stalls++;
            if (bus.bvalid) bhigh++;
        end
        checkOutput("no_second_accept", stalls, 0);
        checkOutput("b_held", bhigh, 5);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        @(posedge aclk); #1;
        @(negedge aclk); checkOutput("b_released", bus.bvalid, 1'b0);
        checkOutput("ifg_unchanged", ifg, m_ifg);

        applyStimulus(1, 8'h14, 32'h0000_0060, 4'hF);
        old_ifg = m_ifg;
        new_ifg = $urandom;
        fork
            axi_write(8'h14, new_ifg, 4'hF, wlat);
            axi_read(8'h14, rd, rlat);
        join
        model_write(8'h14, new_ifg, 4'hF);
        checkOutput("sim_rd_old", rd, old_ifg);
        checkOutput("sim_wr_new", ifg, new_ifg);
        checkOutput("sim_wr_lat", wlat, 2);

        for (int i = 0; i < 80; i++) begin
            stat_pkts   = {$urandom, $urandom};
            stat_octets = {$urandom, $urandom};
            applyStimulus(1'($urandom_range(0, 1)),
                          addr_pool[$urandom_range(0, 13)] | 8'($urandom_range(0, 3)),
                          $urandom, 4'($urandom));
        end
        compare_tpl("rand");

        bus.awaddr = 8'h14; bus.awvalid = 1'b1;
        bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
        @(negedge aclk);
        @(posedge aclk); #1;
        arstn = 1'b0;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        arstn = 1'b1;
        model_reset();
        bcount = 0;
        repeat (6) begin
            @(negedge aclk);
            if (bus.bvalid) bcount++;
        end
        checkOutput("rst_mid_no_b", bcount, 0);
        checkOutput("rst_mid_ifg", ifg, 32'h0);
        applyStimulus(1, 8'h14, 32'h0000_000C, 4'hF);
        applyStimulus(0, 8'h14, 32'h0, 4'h0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule

// File: doc/traffic_generator_gmii_axil_regs.md
Name: traffic_generator_gmii_axil_regs

Overview:
- AXI4-Lite responder (slave) for the traffic_generator_gmii register map; the PS-side master drives it.
- Holds the control, IFG, frame-size and FLIP registers.
- Streams frame-template words into the generator's template RAM.
- Returns 64-bit statistics as coherent hi/lo word pairs.
- Sits between the AXI interconnect and the generator's GMII datapath; same clock as the AXI port.

Parameters:
- IP_ID, 32'h7467_0001, constant returned at offset 0x00.
- TPL_DEPTH, 64, template RAM depth in 32-bit words (power of 2).
- ADDR_W, 8, byte address bits decoded; higher bits are ignored.

Ports:
- aclk  in  1  clock for all logic.
- arstn  in  1  asynchronous active-low reset.
- s_axi_awaddr  in  ADDR_W  write address.
- s_axi_awvalid / s_axi_awready  in/out  1  write-address handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte strobes.
- s_axi_wvalid / s_axi_wready  in/out  1  write-data handshake.
- s_axi_bresp  out  2  write response, always 2'b00.
- s_axi_bvalid / s_axi_bready  out/in  1  write-response handshake.
- s_axi_araddr  in  ADDR_W  read address.
- s_axi_arvalid / s_axi_arready  in/out  1  read-address handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response, always 2'b00.
- s_axi_rvalid / s_axi_rready  out/in  1  read-data handshake.
- ctrl_enable  out  1  control[0].
- ctrl_dynamic  out  1  control[1].
- ifg  out  32  interframe gap (0x14).
- frame_size  out  32  layer-1 frame size (0x44).
- tpl_we  out  1  template write strobe.
- tpl_addr  out  log2(TPL_DEPTH)  template write address.
- tpl_wdata  out  32  template write data.
- tpl_len  out  log2(TPL_DEPTH)+1  number of valid template words.
- stat_pkts  in  64  free-running packet counter.
- stat_octets  in  64  free-running octet counter.

Behaviour:
- Reset (arstn=0, asynchronous):
  - All outputs, registers, tpl pointer, latches and the ovf flag go to 0.
  - All *ready and *valid outputs go to 0.
- Write path FSM W_IDLE -> W_RESP:
  - awready and wready are asserted in W_IDLE. Each channel is captured independently into a holding register; its ready drops once captured.
  - When both are held, the register update happens on the next edge and bvalid is asserted, entering W_RESP.
  - W_RESP holds bvalid until bready. On the bready edge, go to W_IDLE with awready/wready re-asserted.
  - AW and W in the same cycle: latency from handshake to bvalid is 1 cycle.
  - One outstanding write at a time.
- wstrb applies per byte to 0x0C, 0x10, 0x14 and 0x44.
- 0x50 and 0x4C act on any write regardless of wstrb.
- Read path FSM R_IDLE -> R_DATA:
  - arready is high in R_IDLE.
  - On the ar handshake, rdata is registered and rvalid asserted next cycle.
  - R_DATA holds rdata/rvalid stable until rready, then returns to R_IDLE.
  - One outstanding read at a time.
- Read and write paths are fully independent; both may complete in the same cycle.
- Register map (word-aligned; addr[1:0] ignored):
  - 0x00 R: IP_ID.
  - 0x0C RW: write stores the value; read returns its bitwise inverse (FLIP).
  - 0x10 RW: control, bits [1:0]; other bits read 0.
  - 0x14 RW: ifg.
  - 0x18 R: status. [0] = template overflow sticky; [15:8] = tpl_len.
  - 0x20 / 0x24 R: PKTS hi / lo.
  - 0x28 / 0x2C R: OCTETS hi / lo.
  - 0x44 RW: frame_size.
  - 0x4C W: template clear. Pointer and tpl_len go to 0; the ovf flag is cleared.
  - 0x50 W: template push.
  - Unmapped reads return 0 with OKAY. Unmapped writes are ignored with OKAY.
- 64-bit coherence:
  - A read of a hi word returns counter[63:32] and latches counter[31:0] of the same cycle into a per-counter lo latch.
  - A lo read returns that latch, so hi-then-lo yields a consistent snapshot.
  - A lo read without a prior hi read returns the latch's last (or reset) value.
- Template push:
  - Each 0x50 write pulses tpl_we for exactly 1 cycle with tpl_addr = pointer and tpl_wdata = wdata.
  - The pointer then increments and tpl_len = pointer.
  - At pointer == TPL_DEPTH the push is dropped: no tpl_we pulse, status[0] is set, and the pointer saturates (no wrap).
  - A push to 0x50 and a clear to 0x4C cannot coincide (single outstanding write).
- ctrl_enable, ifg and frame_size update on the same edge that asserts bvalid.
- Reset mid-transaction: the transaction is abandoned and no bvalid/rvalid is produced afterwards; the master must reissue.

Test Plan:
- After reset, read 0x00 -> rdata=32'h74670001, rresp=0; bvalid=0, ctrl_enable=0, tpl_len=0.
- Write 0x0C=32'h12345678, read 0x0C -> 32'hEDCBA987. Write with wstrb=4'b0001 value 32'hFFFFFFFF -> read returns 32'hEDCBA900.
- Write 0x4C, then 18 writes to 0x50 (55555555, 555555d5, 01020304 .. 344ca062):
  - 18 tpl_we pulses at addresses 0..17 with matching data.
  - status[15:8]=18.
  - Write 0x10=3 -> ctrl_enable=1, ctrl_dynamic=1.
- Hold stat_pkts=64'h0000_0001_FFFF_FFFF; read 0x20, advance the counter to 64'h2_0000_0005, read 0x24 -> 32'h00000001 then 32'hFFFFFFFF.
- Push TPL_DEPTH+1 words -> exactly TPL_DEPTH tpl_we pulses, status[0]=1; write 0x4C -> status=0.
- Present wvalid 3 cycles before awvalid and hold bready low 5 cycles:
  - bvalid rises 1 cycle after the aw handshake and stays high until bready.
  - No second write is accepted while bvalid is high.
- Issue a simultaneous read of 0x14 and write to 0x14 -> both complete; the read returns the old value.
